// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: data width, opcodes,
// sequencer state encoding and the round-robin pick.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_NOT = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b1000;
   localparam logic [3:0] OP_SLL = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;
   localparam logic [3:0] OP_ROL = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Winning requester ID; only meaningful when at least one request is up.
   function automatic logic rr_winner(input logic req0, input logic req1,
                                      input logic last_id);
      if (req0 && req1) return ~last_id;
      return req1;
   endfunction

endpackage

// File: rtl/scc.sv
// Shared 32-bit ALU. Shift and rotate codes move A by one bit position;
// any undefined opcode behaves as addition.
module scc
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [3:0]        Op,
   output logic [DATA_W-1:0] Out,
   output logic              Zero
);

   always_comb begin
      // NOTE: Out gets a value before the case so no opcode path infers a latch.
      Out = A + B;
      case (Op)
         OP_ADD:  Out = A + B;
         OP_SUB:  Out = A - B;
         OP_AND:  Out = A & B;
         OP_OR:   Out = A | B;
         OP_NOT:  Out = ~A;
         OP_SRA:  Out = {A[DATA_W-1], A[DATA_W-1:1]};
         OP_SLL:  Out = {A[DATA_W-2:0], 1'b0};
         OP_SRL:  Out = {1'b0, A[DATA_W-1:1]};
         OP_ROL:  Out = {A[DATA_W-2:0], A[DATA_W-1]};
         default: Out = A + B;
      endcase
   end

   assign Zero = (Out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of the shared scc ALU:
// grant in IDLE, compute in EXEC, hold the response in RESP until accepted.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req0,
   input  logic [DATA_W-1:0] A0,
   input  logic [DATA_W-1:0] B0,
   input  logic [OP_W-1:0]   Op0,
   input  logic              Req1,
   input  logic [DATA_W-1:0] A1,
   input  logic [DATA_W-1:0] B1,
   input  logic [OP_W-1:0]   Op1,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              Resp_Valid,
   input  logic              Resp_Ready,
   output logic              Resp_Id,
   output logic [DATA_W-1:0] Resp_Out,
   output logic              Resp_Zero,
   output logic              Busy
);

   import alu_pkg::*;

   state_e            state_q, state_d;
   logic              last_id_q, last_id_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              id_q, id_d;
   logic              resp_id_q, resp_id_d;
   logic [DATA_W-1:0] resp_out_q, resp_out_d;
   logic              resp_zero_q, resp_zero_d;

   logic              win_id;
   logic              grant;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zero_unused;

   // Reset gates the grant so no client believes it was served during reset.
   assign win_id = rr_winner(Req0, Req1, last_id_q);
   assign grant  = (state_q == IDLE) && (Req0 || Req1) && !Reset;
   assign Gnt0   = grant && !win_id;
   assign Gnt1   = grant &&  win_id;

   scc u_scc (
      .A    (a_q),
      .B    (b_q),
      .Op   (op_q),
      .Out  (alu_out),
      .Zero (alu_zero_unused)
   );

   always_comb begin
      state_d     = state_q;
      last_id_d   = last_id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      id_d        = id_q;
      resp_id_d   = resp_id_q;
      resp_out_d  = resp_out_q;
      resp_zero_d = resp_zero_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               a_d     = win_id ? A1  : A0;
               b_d     = win_id ? B1  : B0;
               op_d    = win_id ? Op1 : Op0;
               id_d    = win_id;
               state_d = EXEC;
            end
         end
         EXEC: begin
            resp_out_d  = alu_out;
            resp_zero_d = (alu_out == '0);
            resp_id_d   = id_q;
            state_d     = RESP;
         end
         RESP: begin
            if (Resp_Ready) begin
               last_id_d = resp_id_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
      if (Reset) begin
         state_q     <= IDLE;
         last_id_q   <= 1'b1;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         id_q        <= 1'b0;
         resp_id_q   <= 1'b0;
         resp_out_q  <= '0;
         resp_zero_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_id_q   <= last_id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         id_q        <= id_d;
         resp_id_q   <= resp_id_d;
         resp_out_q  <= resp_out_d;
         resp_zero_q <= resp_zero_d;
      end
   end

   assign Resp_Valid = (state_q == RESP);
   assign Busy       = (state_q != IDLE);
   assign Resp_Id    = resp_id_q;
   assign Resp_Out   = resp_out_q;
   assign Resp_Zero  = resp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// transactions scored against an arithmetic model of the ALU and round-robin rule.
module tb_alu_arbiter;

   logic        Clk, Reset;
   logic        Req0, Req1, Resp_Ready;
   logic [31:0] A0, B0, A1, B1;
   logic [3:0]  Op0, Op1;
   logic        Gnt0, Gnt1, Resp_Valid, Resp_Id, Resp_Zero, Busy;
   logic [31:0] Resp_Out;

   int n_checks;
   int n_fail;
   int cyc;
   bit last_served;

   alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req0(Req0), .A0(A0), .B0(B0), .Op0(Op0),
      .Req1(Req1), .A1(A1), .B1(B1), .Op1(Op1),
      .Gnt0(Gnt0), .Gnt1(Gnt1),
      .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready),
      .Resp_Id(Resp_Id), .Resp_Out(Resp_Out), .Resp_Zero(Resp_Zero),
      .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return ~a;
         4'd8:    return a / 2 + (a[31] ? 32'h8000_0000 : 32'h0);
         4'd9:    return a * 2;
         4'd10:   return a / 2;
         4'd12:   return a * 2 + (a >> 31);
         default: return a + b;
      endcase
   endfunction

   task automatic wait_grant(input int budget, output int gid);
      gid = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk);
         if (Gnt0 || Gnt1) begin
            gid = Gnt1 ? 1 : 0;
            return;
         end
      end
   endtask

   task automatic wait_valid(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk);
         if (Resp_Valid) begin
            got = 1'b1;
            return;
         end
      end
   endtask

   // One single-client transaction with Resp_Ready held high; ends just after the handshake edge.
   task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, output int gid, output int lat,
                        output logic [31:0] out, output logic rid, output logic zero);
      int t0;
      bit got;
      if (id) begin Req1 = 1; A1 = a; B1 = b; Op1 = op; end
      else    begin Req0 = 1; A0 = a; B0 = b; Op0 = op; end
      Resp_Ready = 1;
      wait_grant(8, gid);
      t0 = cyc;
      @(posedge Clk); #1;
      Req0 = 0; Req1 = 0;
      wait_valid(8, got);
      lat  = got ? cyc - t0 : -1;
      out  = Resp_Out;
      rid  = Resp_Id;
      zero = Resp_Zero;
      @(posedge Clk); #1;
   endtask

   task automatic test_reset();
      Reset = 1; Req0 = 1; Req1 = 1; Resp_Ready = 1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      n_checks++; if (Gnt0 !== 0 || Gnt1 !== 0) begin n_fail++; $display("FAIL reset_gnt: got %b%b want 00", Gnt0, Gnt1); end
      n_checks++; if (Resp_Valid !== 0 || Busy !== 0) begin n_fail++; $display("FAIL reset_valid_busy: got %b%b want 00", Resp_Valid, Busy); end
      n_checks++; if (Resp_Out !== 0 || Resp_Id !== 0 || Resp_Zero !== 0) begin n_fail++; $display("FAIL reset_resp: out %h id %b zero %b want 0", Resp_Out, Resp_Id, Resp_Zero); end
      @(posedge Clk); #1;
      Reset = 0; Req0 = 0; Req1 = 0;
      @(negedge Clk);
      n_checks++; if (Busy !== 0) begin n_fail++; $display("FAIL reset_idle: busy %b want 0", Busy); end
      @(posedge Clk); #1;
      last_served = 1;
   endtask

   task automatic test_single_add();
      int gid, lat; logic [31:0] out; logic rid, zero;
      do_op(0, 32'd5, 32'd3, 4'b0000, gid, lat, out, rid, zero);
      n_checks++; if (gid !== 0) begin n_fail++; $display("FAIL add_gnt: got %0d want 0", gid); end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
      n_checks++; if (out !== 32'd8 || rid !== 0 || zero !== 0) begin n_fail++; $display("FAIL add_resp: out %h id %b zero %b want 8/0/0", out, rid, zero); end
      last_served = 0;
   endtask

   task automatic test_zero_flag();
      int gid, lat; logic [31:0] out; logic rid, zero;
      do_op(1, 32'd7, 32'd7, 4'b0001, gid, lat, out, rid, zero);
      n_checks++; if (gid !== 1) begin n_fail++; $display("FAIL zero_gnt: got %0d want 1", gid); end
      n_checks++; if (out !== 32'd0 || zero !== 1 || rid !== 1) begin n_fail++; $display("FAIL zero_resp: out %h zero %b id %b want 0/1/1", out, zero, rid); end
      last_served = 1;
   endtask

   task automatic test_shift();
      int gid, lat; logic [31:0] out, expv; logic rid, zero;
      expv = model_alu(4'b1000, 32'h8000_0001, 32'h0);
      do_op(0, 32'h8000_0001, 32'h0, 4'b1000, gid, lat, out, rid, zero);
      n_checks++; if (out !== expv) begin n_fail++; $display("FAIL shift_sra: got %h want %h", out, expv); end
      expv = model_alu(4'b1001, 32'h8000_0001, 32'h0);
      do_op(0, 32'h8000_0001, 32'h0, 4'b1001, gid, lat, out, rid, zero);
      n_checks++; if (out !== expv) begin n_fail++; $display("FAIL shift_sll: got %h want %h", out, expv); end
      last_served = 0;
   endtask

   task automatic test_round_robin();
      int g_id[$], g_cyc[$], r_id[$];
      logic [31:0] r_out[$];
      int expw, n;
      bit both;
      Req0 = 1; A0 = 32'd10;  B0 = 32'd20; Op0 = 4'b0000;
      Req1 = 1; A1 = 32'd100; B1 = 32'd1;  Op1 = 4'b0001;
      Resp_Ready = 1;
      both = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         if (Gnt0 && Gnt1) both = 1;
         if (Gnt0 || Gnt1) begin g_id.push_back(Gnt1 ? 1 : 0); g_cyc.push_back(cyc); end
         if (Resp_Valid) begin r_id.push_back(int'(Resp_Id)); r_out.push_back(Resp_Out); end
      end
      @(posedge Clk); #1;
      Req0 = 0; Req1 = 0;
      n_checks++; if (both) begin n_fail++; $display("FAIL rr_onehot: got both grants want one"); end
      n_checks++; if (g_id.size() != 4 || r_id.size() != 4) begin n_fail++; $display("FAIL rr_count: grants %0d resps %0d want 4/4", g_id.size(), r_id.size()); end
      n = (g_id.size() < r_id.size()) ? g_id.size() : r_id.size();
      expw = last_served ? 0 : 1;
      for (int k = 0; k < n; k++) begin
         n_checks++; if (g_id[k] !== expw) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, g_id[k], expw); end
         n_checks++; if (r_id[k] !== expw) begin n_fail++; $display("FAIL rr_resp_id[%0d]: got %0d want %0d", k, r_id[k], expw); end
         n_checks++; if (r_out[k] !== (expw ? model_alu(Op1, A1, B1) : model_alu(Op0, A0, B0))) begin n_fail++; $display("FAIL rr_resp_out[%0d]: got %h", k, r_out[k]); end
         if (k > 0) begin
            n_checks++; if (g_cyc[k] - g_cyc[k-1] != 3) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want 3", k, g_cyc[k] - g_cyc[k-1]); end
         end
         last_served = expw[0];
         expw = 1 - expw;
      end
   endtask

   task automatic test_backpressure();
      int gid; bit got; logic [31:0] out0, expv; logic id0; bit stable;
      Req0 = 1; A0 = $urandom; B0 = $urandom; Op0 = 4'b0010;
      Resp_Ready = 0;
      expv = model_alu(Op0, A0, B0);
      wait_grant(8, gid);
      n_checks++; if (gid !== 0) begin n_fail++; $display("FAIL bp_gnt0: got %0d want 0", gid); end
      @(posedge Clk); #1;
      Req0 = 0; Req1 = 1; A1 = $urandom; B1 = $urandom; Op1 = 4'b0011;
      wait_valid(8, got);
      out0 = Resp_Out; id0 = Resp_Id;
      n_checks++; if (got !== 1 || out0 !== expv || id0 !== 0) begin n_fail++; $display("FAIL bp_resp: valid %b out %h id %b want 1/%h/0", got, out0, id0, expv); end
      stable = 1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge Clk);
         if (Resp_Valid !== 1 || Resp_Out !== out0 || Resp_Id !== id0 || Gnt1 !== 0) stable = 0;
      end
      n_checks++; if (!stable) begin n_fail++; $display("FAIL bp_hold: response changed or early grant while stalled"); end
      @(posedge Clk); #1;
      Resp_Ready = 1;
      @(negedge Clk);
      n_checks++; if (Gnt1 !== 0 || Resp_Valid !== 1) begin n_fail++; $display("FAIL bp_handshake: gnt1 %b valid %b want 0/1", Gnt1, Resp_Valid); end
      @(negedge Clk);
      n_checks++; if (Gnt1 !== 1) begin n_fail++; $display("FAIL bp_gnt1_after: got %b want 1", Gnt1); end
      expv = model_alu(Op1, A1, B1);
      @(posedge Clk); #1;
      Req1 = 0;
      wait_valid(8, got);
      n_checks++; if (got !== 1 || Resp_Out !== expv || Resp_Id !== 1) begin n_fail++; $display("FAIL bp_resp1: out %h id %b want %h/1", Resp_Out, Resp_Id, expv); end
      @(posedge Clk); #1;
      last_served = 1;
   endtask

   task automatic test_reset_mid();
      int gid, lat; logic [31:0] out; logic rid, zero; bit got, rose;
      do_op(0, 32'd1, 32'd2, 4'b0000, gid, lat, out, rid, zero);
      Req1 = 1; A1 = 32'd9; B1 = 32'd4; Op1 = 4'b0000;
      wait_grant(8, gid);
      n_checks++; if (gid !== 1) begin n_fail++; $display("FAIL rst_mid_gnt: got %0d want 1", gid); end
      @(posedge Clk); #1;
      Req1 = 0; Reset = 1;
      @(posedge Clk); #1;
      Reset = 0;
      @(negedge Clk);
      n_checks++; if (Resp_Valid !== 0 || Busy !== 0) begin n_fail++; $display("FAIL rst_mid_abort: valid %b busy %b want 0/0", Resp_Valid, Busy); end
      rose = 0;
      repeat (4) begin @(negedge Clk); if (Resp_Valid) rose = 1; end
      n_checks++; if (rose) begin n_fail++; $display("FAIL rst_mid_no_valid: got valid after abort want none"); end
      last_served = 1;
      @(posedge Clk); #1;
      Req0 = 1; Req1 = 1; Resp_Ready = 1;
      wait_grant(8, gid);
      n_checks++; if (gid !== (last_served ? 0 : 1)) begin n_fail++; $display("FAIL rst_mid_tie: got %0d want 0", gid); end
      @(posedge Clk); #1;
      Req0 = 0; Req1 = 0;
      wait_valid(8, got);
      @(posedge Clk); #1;
      last_served = 0;
   endtask

   task automatic test_random();
      logic [3:0] ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd12, 4'd5, 4'd15};
      int r, expw, gid, stall; bit got, held; logic [31:0] a, b, expv; logic [3:0] op;
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(1, 3);
         a = $urandom; b = ($urandom_range(0, 3) == 0) ? -a : $urandom;
         op = ops[$urandom_range(0, 10)];
         A0 = a; B0 = b; Op0 = op; A1 = a; B1 = b; Op1 = op;
         A0 = (r == 3) ? ~a : a;
         Req0 = r[0]; Req1 = r[1];
         Resp_Ready = $urandom_range(0, 1);
         expw = (r == 3) ? (last_served ? 0 : 1) : (r[1] ? 1 : 0);
         expv = model_alu(op, expw ? A1 : A0, b);
         wait_grant(8, gid);
         n_checks++; if (gid !== expw) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %0d want %0d", t, gid, expw); end
         stall = $urandom_range(0, 3);
         @(posedge Clk); #1;
         Req0 = 0; Req1 = 0; Resp_Ready = (stall == 0);
         wait_valid(8, got);
         n_checks++; if (got !== 1 || Resp_Out !== expv || Resp_Zero !== (expv == 0) || Resp_Id !== expw[0]) begin
            n_fail++; $display("FAIL rand_resp[%0d]: out %h zero %b id %b want %h/%b/%0d", t, Resp_Out, Resp_Zero, Resp_Id, expv, (expv == 0), expw);
         end
         if (stall > 0) begin
            held = 1;
            repeat (stall) begin @(negedge Clk); if (Resp_Valid !== 1 || Resp_Out !== expv) held = 0; end
            n_checks++; if (!held) begin n_fail++; $display("FAIL rand_stall[%0d]: response not held", t); end
            @(posedge Clk); #1;
            Resp_Ready = 1;
            @(negedge Clk);
         end
         @(posedge Clk); #1;
         last_served = expw[0];
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; last_served = 1;
      Reset = 1; Req0 = 0; Req1 = 0; Resp_Ready = 0;
      A0 = 0; B0 = 0; A1 = 0; B1 = 0; Op0 = 0; Op1 = 0;
      test_reset();
      test_single_add();
      test_zero_flag();
      test_shift();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (`scc`). It accepts operation requests (A, B, Op) from two clients and grants one at a time in round-robin order. It registers the winner's operands, runs them through the ALU, and returns the result, a Zero flag and the requester ID over a valid/ready response channel. It sits between the datapath clients and the single ALU instance they share.

## Interface
Parameters:
- DATA_W, 32, operand/result width; fixed at 32 to match `scc`.
- OP_W, 4, opcode width.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0 / Req1  in  1  request from client 0 / 1; held until granted.
- A0, B0 / A1, B1  in  DATA_W  operands; stable while ReqN is high.
- Op0 / Op1  in  OP_W  ALU opcode; stable while ReqN is high.
- Gnt0 / Gnt1  out  1  one-cycle grant pulse; operands are captured on this cycle.
- Resp_Valid  out  1  response available.
- Resp_Ready  in  1  consumer accepts the response.
- Resp_Id  out  1  ID of the served requester.
- Resp_Out  out  DATA_W  ALU result.
- Resp_Zero  out  1  high when Resp_Out == 0.
- Busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset enters IDLE.
- **IDLE:**
  - If no request is pending, remain in IDLE.
  - Otherwise select a winner. With a single requester, it wins. With both, the winner is the requester ≠ Last_Id.
  - Gnt of the winner is combinational: state==IDLE and winner. Only one Gnt is high per cycle.
  - Capture A, B, Op and Id of the winner into the operand registers. Next state is EXEC.
- **EXEC:**
  - The ALU operates on the registered operands.
  - Register Resp_Out = ALU Out and Resp_Zero = (ALU Out == 0). Next state is RESP.
- **RESP:**
  - Resp_Valid = 1.
  - On Resp_Valid & Resp_Ready: Last_Id ← Resp_Id and next state is IDLE.
  - Otherwise Resp_Id, Resp_Out and Resp_Zero hold unchanged.
- **Opcodes:**
  - Opcodes pass unchanged to `scc`.
  - Undefined codes get the ALU default (addition). The arbiter performs no opcode check.
- **Zero:** Zero is computed in the arbiter. The ALU Zero port is left unused.
- **Reset values:**
  - State = IDLE, Last_Id = 1, so client 0 wins the first tie.
  - Gnt0 = Gnt1 = 0 (because Reset forces the IDLE/grant logic off), Resp_Valid = 0, Busy = 0.
  - Resp_Id = 0, Resp_Out = 0, Resp_Zero = 0, and the operand registers are 0.
- **Boundary conditions:**
  - A request deasserted before its grant is dropped without trace.
  - A requester that re-raises Req after being served loses the next tie.
  - Requests arriving during EXEC/RESP wait. No Gnt is issued outside IDLE.
  - Reset asserted in any state aborts the operation. The response is discarded and Resp_Valid = 0 on the following cycle.
  - Resp_Ready high outside RESP is ignored.
  - Arithmetic wraps modulo 2^32. There is no carry or overflow output.

## Timing
- Gnt is asserted in cycle T, EXEC occupies T+1, and Resp_Valid rises in T+2.
- Minimum interval between grants is 3 cycles (Resp_Ready held high). Each stall cycle on Resp_Ready adds one cycle.
- Gnt is combinational from Req and state. All other outputs are registered.
- There is no combinational path from Resp_Ready to any output except through state.

## Structure
- A shared package `alu_pkg` holds:
  - opcode constants: OP_ADD=4'b0000, OP_SUB=4'b0001, OP_AND=4'b0010, OP_OR=4'b0011, OP_NOT=4'b0100, OP_SRA=4'b1000, OP_SLL=4'b1001, OP_SRL=4'b1010, OP_ROL=4'b1100;
  - DATA_W;
  - the FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One sub-module: the existing `scc` ALU, instantiated once inside alu_arbiter and fed from the operand registers.
- Round-robin select is a small combinational function of Req0, Req1 and Last_Id.

## Test plan
- **Single add.** After reset, Req0 with A0=5, B0=3, Op0=0000 and Resp_Ready=1.
  - Expect Gnt0 at T and Resp_Valid at T+2.
  - Expect Resp_Out=8, Resp_Id=0, Resp_Zero=0.
- **Zero flag.** Req1 with A1=7, B1=7, Op1=0001.
  - Expect Resp_Out=0, Resp_Zero=1, Resp_Id=1.
- **Round-robin.** Req0 and Req1 both held high continuously.
  - Expect grants in order 0,1,0,1, each 3 cycles apart.
  - Expect Resp_Id to alternate correspondingly.
- **Backpressure.** Resp_Ready low for 4 cycles while in RESP, with Req1 pending.
  - Expect Resp_Valid, Resp_Out and Resp_Id stable throughout.
  - Expect no Gnt1 until the cycle after the handshake.
- **Shift.** Req0 with A0=32'h80000001, Op0=1000.
  - Expect Resp_Out=32'hC0000000.
  - With Op0=1001, expect 32'h00000002.
- **Reset mid-operation.** Assert Reset during EXEC.
  - Expect Resp_Valid never rises and Busy=0 next cycle.
  - Afterwards both Req high: expect Gnt0 first (Last_Id restored to 1).
